// File: rtl/f1d16_arb4_pkg.sv
// Shared definitions for the f1d16_arb4 four-requester burst arbiter:
// FSM encoding, requester count and default widths.
package f1d16_arb4_pkg;

    localparam int NREQ          = 4;
    localparam int DEF_W         = 16;
    localparam int DEF_MAX_BURST = 4;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_BURST    = 2'd1,
        ST_FLUSHING = 2'd2
    } state_t;

    function automatic logic [1:0] onehot_to_idx(input logic [NREQ-1:0] oh);
        logic [1:0] idx;
        idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (oh[i]) begin
                idx = idx | 2'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/f1d16_arb4_rr_pick4.sv
// Round-robin search: first set request at or after ptr, wrapping 3 -> 0.
// Purely combinational; returns a one-hot winner and a found flag.
module rr_pick4
    import f1d16_arb4_pkg::*;
(
    input  logic [NREQ-1:0] req,
    input  logic [1:0]      ptr,
    output logic [NREQ-1:0] winner,
    output logic            found
);

    always_comb begin
        winner = '0;
        found  = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (!found && req[ptr + 2'(k)]) begin
                winner[ptr + 2'(k)] = 1'b1;
                found               = 1'b1;
            end
        end
    end

endmodule

// File: rtl/f1d16_arb4.sv
// Four-requester round-robin burst arbiter feeding a shared W-bit register,
// with a synchronous flush path that clears the register for one cycle.
module f1d16_arb4
    import f1d16_arb4_pkg::*;
#(
    parameter int W         = DEF_W,
    parameter int MAX_BURST = DEF_MAX_BURST
) (
    input  logic              ck,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*W-1:0] d,
    input  logic              flush,
    output logic [NREQ-1:0]   gnt,
    output logic              reg_ce,
    output logic              reg_clr,
    output logic [W-1:0]      reg_d,
    output logic [W-1:0]      q,
    output logic              q_valid,
    output logic [1:0]        q_id
);

    state_t          state_q, state_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [1:0]      ptr_q, ptr_d;
    logic [1:0]      owner_q, owner_d;
    logic            loaded_q;
    logic [NREQ-1:0] winner;
    logic            found;
    logic [1:0]      win_idx;

    // ptr is moved to winner+1 at grant time, so a flush that aborts a burst
    // leaves it already pointing past the interrupted owner.
    rr_pick4 u_pick (
        .req    (req),
        .ptr    (ptr_q),
        .winner (winner),
        .found  (found)
    );

    assign win_idx = onehot_to_idx(winner);

    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            cnt_q   <= '0;
            ptr_q   <= '0;
            owner_q <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = '0;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        if (flush) begin
            state_d = ST_FLUSHING;
            cnt_d   = '0;
        end else if (state_q == ST_BURST && req[owner_q] && cnt_q < 4'(MAX_BURST)) begin
            gnt_d = gnt_q;
            cnt_d = cnt_q + 4'd1;
        end else if (found) begin
            // A lone requester at its burst limit wins again through the wrap.
            state_d = ST_BURST;
            gnt_d   = winner;
            owner_d = win_idx;
            ptr_d   = win_idx + 2'd1;
            cnt_d   = 4'd1;
        end else begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end
    end

    always_comb begin
        reg_d = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_q[i]) begin
                reg_d = reg_d | d[i*W +: W];
            end
        end
    end

    assign gnt     = gnt_q;
    assign reg_ce  = |gnt_q;
    assign reg_clr = (state_q == ST_FLUSHING);

    // Shared register: async clear from reset, sync clear from the flush strobe.
    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            q        <= '0;
            loaded_q <= 1'b0;
            q_id     <= '0;
        end else begin
            loaded_q <= reg_ce;
            if (reg_clr) begin
                q <= '0;
            end else if (reg_ce) begin
                q <= reg_d;
            end
            if (reg_ce) begin
                q_id <= owner_q;
            end
        end
    end

    assign q_valid = loaded_q & ~reg_clr;

endmodule

// File: tb/tb_f1d16_arb4.sv
// Directed self-checking bench for f1d16_arb4 with per-cycle invariant checks.
module tb_f1d16_arb4;

    logic        ck;
    logic        rst_n;
    logic [3:0]  req;
    logic [63:0] d;
    logic        flush;
    logic [3:0]  gnt;
    logic        reg_ce;
    logic        reg_clr;
    logic [15:0] reg_d;
    logic [15:0] q;
    logic        q_valid;
    logic [1:0]  q_id;

    int   errors = 0;
    int   checks = 0;
    logic prev_ce = 1'b0;

    f1d16_arb4 #(.W(16), .MAX_BURST(4)) dut (
        .ck      (ck),
        .rst_n   (rst_n),
        .req     (req),
        .d       (d),
        .flush   (flush),
        .gnt     (gnt),
        .reg_ce  (reg_ce),
        .reg_clr (reg_clr),
        .reg_d   (reg_d),
        .q       (q),
        .q_valid (q_valid),
        .q_id    (q_id)
    );

    initial ck = 1'b0;
    always #5 ck = ~ck;

    function automatic logic [15:0] word_of(input int i);
        case (i)
            0:       return 16'hA000;
            1:       return 16'hB111;
            2:       return 16'h1234;
            default: return 16'hC333;
        endcase
    endfunction

    // Every-cycle invariants; q_valid is expected one cycle after reg_ce unless clearing.
    task automatic check_invariants;
        if (rst_n) begin
            checks++;
            if ($countones(gnt) > 1) begin
                errors++;
                $display("[TB] FAIL inv_onehot: gnt=%b required at most one bit", gnt);
            end
            checks++;
            if (reg_ce !== (|gnt)) begin
                errors++;
                $display("[TB] FAIL inv_ce: reg_ce=%b required %b", reg_ce, |gnt);
            end
            checks++;
            if (reg_ce && reg_clr) begin
                errors++;
                $display("[TB] FAIL inv_ce_clr: reg_ce=1 reg_clr=1 required not both");
            end
            checks++;
            if (q_valid !== (prev_ce & ~reg_clr)) begin
                errors++;
                $display("[TB] FAIL inv_qvalid: q_valid=%b required %b", q_valid, prev_ce & ~reg_clr);
            end
            prev_ce = reg_ce;
        end else begin
            prev_ce = 1'b0;
        end
    endtask

    task automatic tick;
        @(posedge ck);
        #1;
        check_invariants();
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        req   = 4'b0000;
        flush = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        req   = 4'b0000;
        flush = 1'b0;
        d     = {word_of(3), word_of(2), word_of(1), word_of(0)};
        tick();
        tick();
        checks++;
        if (gnt !== 4'b0000 || reg_ce !== 1'b0 || reg_clr !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_ctrl: gnt=%b ce=%b clr=%b required 0000 0 0", gnt, reg_ce, reg_clr);
        end
        checks++;
        if (reg_d !== 16'h0 || q !== 16'h0 || q_valid !== 1'b0 || q_id !== 2'd0) begin
            errors++;
            $display("[TB] FAIL reset_data: reg_d=%h q=%h qv=%b qid=%0d required all zero", reg_d, q, q_valid, q_id);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (gnt !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL reset_idle: gnt=%b required 0000", gnt);
        end
    endtask

    task automatic test_single;
        logic [3:0] exp_gnt;
        do_reset();
        req = 4'b0100;
        for (int c = 1; c <= 8; c++) begin
            tick();
            if (c == 6) req = 4'b0000;
            exp_gnt = (c <= 6) ? 4'b0100 : 4'b0000;
            checks++;
            if (gnt !== exp_gnt) begin
                errors++;
                $display("[TB] FAIL single_gnt c=%0d: gnt=%b required %b", c, gnt, exp_gnt);
            end
            if (c == 1) begin
                checks++;
                if (reg_d !== 16'h1234) begin
                    errors++;
                    $display("[TB] FAIL single_regd: reg_d=%h required 1234", reg_d);
                end
            end
            if (c >= 2 && c <= 7) begin
                checks++;
                if (q !== 16'h1234 || q_valid !== 1'b1 || q_id !== 2'd2) begin
                    errors++;
                    $display("[TB] FAIL single_q c=%0d: q=%h qv=%b qid=%0d required 1234 1 2", c, q, q_valid, q_id);
                end
            end
        end
        checks++;
        if (q !== 16'h1234 || q_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL single_hold: q=%h qv=%b required 1234 0", q, q_valid);
        end
    endtask

    task automatic test_all_four;
        int         owner;
        logic [3:0] exp_gnt;
        do_reset();
        req = 4'b1111;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (c == 20) req = 4'b0000;
            owner   = ((c - 1) / 4) % 4;
            exp_gnt = 4'b0001 << owner;
            checks++;
            if (gnt !== exp_gnt) begin
                errors++;
                $display("[TB] FAIL all4_gnt c=%0d: gnt=%b required %b", c, gnt, exp_gnt);
            end
            if (c >= 2) begin
                owner = ((c - 2) / 4) % 4;
                checks++;
                if (q_id !== 2'(owner) || q !== word_of(owner)) begin
                    errors++;
                    $display("[TB] FAIL all4_q c=%0d: qid=%0d q=%h required %0d %h", c, q_id, q, owner, word_of(owner));
                end
            end
        end
        tick();
        checks++;
        if (gnt !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL all4_end: gnt=%b required 0000", gnt);
        end
    endtask

    task automatic test_rr_ptr;
        logic [3:0] exp_seq [6];
        exp_seq = '{4'b0010, 4'b0000, 4'b1000, 4'b1000, 4'b0010, 4'b0000};
        do_reset();
        req = 4'b0010;
        for (int c = 1; c <= 6; c++) begin
            tick();
            case (c)
                1:       req = 4'b0000;
                2:       req = 4'b1010;
                4:       req = 4'b0010;
                5:       req = 4'b0000;
                default: ;
            endcase
            checks++;
            if (gnt !== exp_seq[c-1]) begin
                errors++;
                $display("[TB] FAIL rr_ptr c=%0d: gnt=%b required %b", c, gnt, exp_seq[c-1]);
            end
        end
    endtask

    task automatic test_flush;
        logic [3:0] exp_gnt [11];
        logic       exp_clr [11];
        exp_gnt = '{4'b0010, 4'b0010, 4'b0000, 4'b0100, 4'b0000, 4'b0010,
                    4'b0010, 4'b0000, 4'b0000, 4'b0010, 4'b0000};
        exp_clr = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0,
                    1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        do_reset();
        req = 4'b0110;
        for (int c = 1; c <= 11; c++) begin
            tick();
            case (c)
                2:       flush = 1'b1;
                3:       flush = 1'b0;
                4:       req   = 4'b0000;
                5:       req   = 4'b0010;
                7:       flush = 1'b1;
                9:       flush = 1'b0;
                10:      req   = 4'b0000;
                default: ;
            endcase
            checks++;
            if (gnt !== exp_gnt[c-1] || reg_clr !== exp_clr[c-1]) begin
                errors++;
                $display("[TB] FAIL flush_seq c=%0d: gnt=%b clr=%b required %b %b", c, gnt, reg_clr, exp_gnt[c-1], exp_clr[c-1]);
            end
            if (c == 3 || c == 8) begin
                checks++;
                if (q !== 16'hB111 || q_valid !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL flush_load c=%0d: q=%h qv=%b required b111 0", c, q, q_valid);
                end
            end
            if (c == 4 || c == 9) begin
                checks++;
                if (q !== 16'h0000) begin
                    errors++;
                    $display("[TB] FAIL flush_clear c=%0d: q=%h required 0000", c, q);
                end
            end
            if (c == 5) begin
                checks++;
                if (q !== 16'h1234 || q_valid !== 1'b1 || q_id !== 2'd2) begin
                    errors++;
                    $display("[TB] FAIL flush_next: q=%h qv=%b qid=%0d required 1234 1 2", q, q_valid, q_id);
                end
            end
        end
    endtask

    task automatic test_reset_mid;
        do_reset();
        req = 4'b0100;
        tick();
        tick();
        tick();
        checks++;
        if (gnt !== 4'b0100 || q_id !== 2'd2) begin
            errors++;
            $display("[TB] FAIL mid_pre: gnt=%b qid=%0d required 0100 2", gnt, q_id);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (gnt !== 4'b0000 || reg_ce !== 1'b0 || reg_clr !== 1'b0 || reg_d !== 16'h0) begin
            errors++;
            $display("[TB] FAIL mid_async_ctrl: gnt=%b ce=%b clr=%b regd=%h required zero", gnt, reg_ce, reg_clr, reg_d);
        end
        checks++;
        if (q !== 16'h0 || q_valid !== 1'b0 || q_id !== 2'd0) begin
            errors++;
            $display("[TB] FAIL mid_async_q: q=%h qv=%b qid=%0d required zero", q, q_valid, q_id);
        end
        tick();
        #2;
        rst_n = 1'b1;
        req   = 4'b1111;
        tick();
        req = 4'b0000;
        checks++;
        if (gnt !== 4'b0001 || reg_d !== 16'hA000) begin
            errors++;
            $display("[TB] FAIL mid_restart: gnt=%b regd=%h required 0001 a000", gnt, reg_d);
        end
        tick();
        checks++;
        if (gnt !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL mid_end: gnt=%b required 0000", gnt);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_all_four();
        test_rr_ptr();
        test_flush();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time exceeded, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/f1d16_arb4.md
F1D16_ARB4 -- requirements
Module: f1d16_arb4

Interface
REQ-001 Parameter W, default 16, data width of the shared delay register.
REQ-002 Parameter NREQ, fixed at 4, number of requesters.
REQ-003 Parameter MAX_BURST, default 4, range 1..15, maximum consecutive words granted to one requester.
REQ-004 CK  input  1  single clock; all state updates on the rising edge.
REQ-005 RST_N  input  1  asynchronous, active-low reset.
REQ-006 REQ  input  4  per-requester request; held high while the requester has data.
REQ-007 D  input  4*W  requester data; D[i*W +: W] belongs to requester i.
REQ-008 FLUSH  input  1  synchronous clear request for the shared register.
REQ-009 GNT  output  4  registered one-hot grant; D[i] is consumed in every cycle where GNT[i]=1.
REQ-010 REG_CE  output  1  clock enable of the shared 16-bit register; equals OR of GNT.
REQ-011 REG_CLR  output  1  one-cycle clear strobe of the shared register.
REQ-012 REG_D  output  W  data selected by GNT; zero when GNT=0.
REQ-013 Q  output  W  internal shared register contents.
REQ-014 Q_VALID  output  1  Q was loaded on the previous edge.
REQ-015 Q_ID  output  2  requester index of the word in Q.

Function
REQ-016 FSM states: IDLE (no grant), BURST (GNT one-hot), FLUSHING (REG_CLR=1, GNT=0).
REQ-017 IDLE -> BURST when any REQ=1 and FLUSH=0; the winner is the first set REQ at or after round-robin pointer PTR, searched in ascending index with wrap-around 3->0.
REQ-018 Grant latency: REQ[i] high in cycle t with an idle arbiter gives GNT[i]=1 in cycle t+1.
REQ-019 In BURST the grant is held while REQ[owner]=1 and burst count < MAX_BURST; each GNT cycle transfers one word and increments the count.
REQ-020 Burst end on REQ[owner]=0 or count=MAX_BURST: PTR <= owner+1 (mod 4); the next owner is chosen in the same edge with no idle cycle if another REQ is set. Otherwise the FSM moves to IDLE.
REQ-021 At count=MAX_BURST, when the owner is the only requester, it is re-granted with the count reset; the arbiter does not starve a lone requester.
REQ-022 REQ[owner] dropping while GNT[owner]=1: that cycle still transfers, since GNT is registered. Requesters deassert REQ in the cycle after their last granted word.
REQ-023 Q loads REG_D on an edge where REG_CE=1. Q_VALID=1 and Q_ID=owner in the following cycle; otherwise Q_VALID=0 and Q holds.
REQ-024 FLUSH=1 in any state: on the next edge enter FLUSHING for exactly one cycle. GNT=0, REG_CLR=1, Q cleared to 0 at the end of that cycle, any burst aborted, and PTR unchanged.
REQ-025 FLUSH held high keeps the FSM in FLUSHING; the FSM leaves FLUSHING to IDLE, or directly to BURST per REQ-017, in the cycle after FLUSH=0.
REQ-026 A word granted in the same cycle FLUSH rises is still loaded. Q_VALID for that word is suppressed if REG_CLR is asserted in its valid cycle.
REQ-027 GNT shall never have more than one bit set; REG_CE and REG_CLR shall never be high together.

Reset
REQ-028 RST_N=0 forces asynchronously: state IDLE, GNT=0, REG_CE=0, REG_CLR=0, REG_D=0, Q=0, Q_VALID=0, Q_ID=0, PTR=0, burst count=0.
REQ-029 Reset asserted mid-burst aborts the burst with no partial transfer; the first grant after release follows REQ-018 from PTR=0.

Structure
REQ-030 A shared package holds the FSM state encoding, NREQ, and the default W and MAX_BURST.
REQ-031 The round-robin next-owner search is one sub-module, rr_pick4: inputs REQ and PTR, outputs a one-hot winner and a found flag. It is purely combinational.
REQ-032 The shared register is instantiated inside the block with async clear from RST_N, synchronous clear from REG_CLR, and enable from REG_CE.

Verification
REQ-033 Single requester: REQ=0100 held for 6 cycles, D2=0x1234 -> GNT=0100 from cycle 1 for 4 cycles. Count reset, then 2 more grants, with no gap. Q=0x1234 and Q_ID=2 valid.
REQ-034 All four requesting continuously, MAX_BURST=4 -> grant order 0,1,2,3,0, with 4 words each and no idle cycles between bursts.
REQ-035 REQ=1010 with PTR=2 -> requester 3 is granted first, then 1.
REQ-036 FLUSH pulsed during the 2nd word of a burst from requester 1 -> that word loads. Next cycle REG_CLR=1, GNT=0, and Q=0. Requester 2 is granted after, if requesting; otherwise requester 1 resumes.
REQ-037 RST_N low for 1 cycle mid-burst -> all outputs 0 immediately, without waiting for an edge. After release, REQ=1111 gives GNT=0001 first.
REQ-038 Assertion checks on every cycle: GNT is one-hot or zero, REG_CE=|GNT, REG_CE and REG_CLR are never both 1, and Q_VALID follows REG_CE by exactly one cycle.
